// File: rtl/multi_lane_field_iter.sv
// multi_lane_field_iter
//
// This block sweeps a Game of Life field in raster order and handles LANES
// horizontally adjacent cells on each clock. Each cycle it issues the read
// address of the next group and registers that group's current states and
// neighbour vectors. It applies the B3/S23 rule to every lane and presents
// the result as write data for the group now at o_cur_x/o_cur_y.
//
// At the end of each completed sweep it flips the double-buffer selector
// (FIELD_A=0, FIELD_B=1).
//
// Optional feature: define POP_CNT_EN to count the live cells written in each
// generation. When POP_CNT_EN is not defined, o_pop_cnt is tied to 0.
//
// Ports
//   clk, rst               clock, synchronous active-high reset
//   i_go                   start one generation (taken in IDLE/DONE)
//   i_run                  level: start generations back-to-back
//   i_abort                abandon the current sweep (SIM only)
//   i_next_cell_states     states of the group at o_next_x/o_next_y, lane k = x+k
//   i_next_nbrs            neighbour vectors, lane k in bits [8k+7:8k]
//   o_is_simulating        high while sweeping
//   o_cur_x, o_cur_y       group being written (x of lane 0)
//   o_next_x, o_next_y     read address of the next group
//   o_new_cur_cell_states  new states for the o_cur group
//   o_write_en             write strobe (same as o_is_simulating)
//   o_cur_read_field       field currently read from
//   o_gen_done             one-cycle pulse after a completed sweep
//   o_gen_cnt              completed generations, wraps
//   o_pop_cnt              live cells written in the last completed generation
module multi_lane_field_iter #(
    parameter int FIELD_W = 8,
    parameter int FIELD_H = 4,
    parameter int LANES   = 2,
    parameter int GEN_W   = 16,
    localparam int X_ADR_SIZE     = $clog2(FIELD_W),
    localparam int Y_ADR_SIZE     = $clog2(FIELD_H),
    localparam int NEIGHBOURS_CNT = 8,
    localparam int POP_W          = $clog2(FIELD_W * FIELD_H + 1)
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               i_go,
    input  logic                               i_run,
    input  logic                               i_abort,
    input  logic [LANES-1:0]                   i_next_cell_states,
    input  logic [LANES*NEIGHBOURS_CNT-1:0]    i_next_nbrs,
    output logic                               o_is_simulating,
    output logic [X_ADR_SIZE-1:0]              o_cur_x,
    output logic [Y_ADR_SIZE-1:0]              o_cur_y,
    output logic [X_ADR_SIZE-1:0]              o_next_x,
    output logic [Y_ADR_SIZE-1:0]              o_next_y,
    output logic [LANES-1:0]                   o_new_cur_cell_states,
    output logic                               o_write_en,
    output logic                               o_cur_read_field,
    output logic                               o_gen_done,
    output logic [GEN_W-1:0]                   o_gen_cnt,
    output logic [POP_W-1:0]                   o_pop_cnt
);

    typedef enum logic [1:0] {IDLE, SIM, DONE} state_t;
    typedef enum logic {FIELD_A = 1'b0, FIELD_B = 1'b1} cur_field_t;

    localparam logic [X_ADR_SIZE-1:0] X_LAST = X_ADR_SIZE'(FIELD_W - LANES);
    localparam logic [Y_ADR_SIZE-1:0] Y_LAST = Y_ADR_SIZE'(FIELD_H - 1);
    // When one group spans the whole row the x step is never taken.
    localparam logic [X_ADR_SIZE-1:0] X_STEP = X_ADR_SIZE'(LANES % FIELD_W);

    // Conway B3/S23 rule for a single cell.
    function automatic logic next_cell_state(input logic cur,
                                             input logic [NEIGHBOURS_CNT-1:0] nbrs);
        logic [3:0] live;
        live = '0;
        for (int i = 0; i < NEIGHBOURS_CNT; i++) begin
            live = live + 4'(nbrs[i]);
        end
        return (live == 4'd3) || (cur && (live == 4'd2));
    endfunction

    state_t                          state_q, state_d;
    cur_field_t                      field_q, field_d;
    logic [X_ADR_SIZE-1:0]           cur_x_q, cur_x_d, next_x_q, next_x_d;
    logic [Y_ADR_SIZE-1:0]           cur_y_q, cur_y_d, next_y_q, next_y_d;
    logic [LANES-1:0]                states_q, states_d;
    logic [LANES*NEIGHBOURS_CNT-1:0] nbrs_q, nbrs_d;
    logic [GEN_W-1:0]                gen_cnt_q, gen_cnt_d;
    logic [LANES-1:0]                rule_out;
    logic                            sweep_last;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        assign rule_out[k] = next_cell_state(states_q[k],
                                             nbrs_q[NEIGHBOURS_CNT*k +: NEIGHBOURS_CNT]);
    end

    assign sweep_last = (cur_x_q == X_LAST) && (cur_y_q == Y_LAST);

    always_comb begin
        state_d   = state_q;
        field_d   = field_q;
        gen_cnt_d = gen_cnt_q;
        cur_x_d   = '0;
        cur_y_d   = '0;
        next_x_d  = '0;
        next_y_d  = '0;
        states_d  = i_next_cell_states;
        nbrs_d    = i_next_nbrs;

        case (state_q)
            IDLE: if (i_go || i_run) state_d = SIM;
            SIM: begin
                // Abort wins over the end of the sweep: nothing is committed.
                if (i_abort) begin
                    state_d = IDLE;
                end else if (sweep_last) begin
                    state_d   = DONE;
                    field_d   = (field_q == FIELD_A) ? FIELD_B : FIELD_A;
                    gen_cnt_d = gen_cnt_q + GEN_W'(1);
                end
            end
            DONE: state_d = (i_go || i_run) ? SIM : IDLE;
            default: state_d = IDLE;
        endcase

        // Outside SIM the read address parks at (0,0), so the group presented
        // in an IDLE/DONE start cycle is always the first one.
        if (state_d == SIM) begin
            cur_x_d = next_x_q;
            cur_y_d = next_y_q;
            if (next_x_q == X_LAST) begin
                next_x_d = '0;
                next_y_d = (next_y_q == Y_LAST) ? '0 : next_y_q + Y_ADR_SIZE'(1);
            end else begin
                next_x_d = next_x_q + X_STEP;
                next_y_d = next_y_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            field_q   <= FIELD_A;
            gen_cnt_q <= '0;
            cur_x_q   <= '0;
            cur_y_q   <= '0;
            next_x_q  <= '0;
            next_y_q  <= '0;
            states_q  <= '0;
            nbrs_q    <= '0;
        end else begin
            state_q   <= state_d;
            field_q   <= field_d;
            gen_cnt_q <= gen_cnt_d;
            cur_x_q   <= cur_x_d;
            cur_y_q   <= cur_y_d;
            next_x_q  <= next_x_d;
            next_y_q  <= next_y_d;
            states_q  <= states_d;
            nbrs_q    <= nbrs_d;
        end
    end

    assign o_is_simulating       = (state_q == SIM);
    assign o_write_en            = (state_q == SIM);
    assign o_gen_done            = (state_q == DONE);
    assign o_cur_x               = cur_x_q;
    assign o_cur_y               = cur_y_q;
    assign o_next_x              = next_x_q;
    assign o_next_y              = next_y_q;
    assign o_cur_read_field      = field_q;
    assign o_gen_cnt             = gen_cnt_q;
    // Write data is only meaningful while writing; keep it quiet otherwise.
    assign o_new_cur_cell_states = (state_q == SIM) ? rule_out : '0;

`ifdef POP_CNT_EN
    function automatic logic [POP_W-1:0] popcount(input logic [LANES-1:0] v);
        logic [POP_W-1:0] n;
        n = '0;
        for (int i = 0; i < LANES; i++) begin
            n = n + POP_W'(v[i]);
        end
        return n;
    endfunction

    logic [POP_W-1:0] acc_q, acc_d, pop_q, pop_d;

    always_comb begin
        acc_d = acc_q;
        pop_d = pop_q;
        if (state_q != SIM && state_d == SIM) begin
            acc_d = '0;
        end else if (state_q == SIM) begin
            acc_d = acc_q + popcount(o_new_cur_cell_states);
        end
        // The last group is still on the write bus in the cycle we leave SIM.
        if (state_q == SIM && state_d == DONE) begin
            pop_d = acc_q + popcount(o_new_cur_cell_states);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
            pop_q <= '0;
        end else begin
            acc_q <= acc_d;
            pop_q <= pop_d;
        end
    end

    assign o_pop_cnt = pop_q;
`else
    assign o_pop_cnt = '0;
`endif

endmodule

// File: tb/tb_multi_lane_field_iter.sv
// Testbench for multi_lane_field_iter (FIELD_W=8, FIELD_H=4, LANES=2).
// It drives random cell data and compares the DUT against a group-index
// model that is built from the Game of Life rule.
module tb_multi_lane_field_iter;
    localparam int W  = 8;
    localparam int H  = 4;
    localparam int L  = 2;
    localparam int GW = 16;
    localparam int N  = W * H / L;
    localparam int XA = $clog2(W);
    localparam int YA = $clog2(H);
    localparam int PW = $clog2(W * H + 1);

    logic            clk = 1'b0;
    logic            rst;
    logic            i_go, i_run, i_abort;
    logic [L-1:0]    i_next_cell_states;
    logic [L*8-1:0]  i_next_nbrs;
    logic            o_is_simulating, o_write_en, o_cur_read_field, o_gen_done;
    logic [XA-1:0]   o_cur_x, o_next_x;
    logic [YA-1:0]   o_cur_y, o_next_y;
    logic [L-1:0]    o_new_cur_cell_states;
    logic [GW-1:0]   o_gen_cnt;
    logic [PW-1:0]   o_pop_cnt;

    multi_lane_field_iter #(.FIELD_W(W), .FIELD_H(H), .LANES(L), .GEN_W(GW)) dut (
        .clk(clk), .rst(rst), .i_go(i_go), .i_run(i_run), .i_abort(i_abort),
        .i_next_cell_states(i_next_cell_states), .i_next_nbrs(i_next_nbrs),
        .o_is_simulating(o_is_simulating), .o_cur_x(o_cur_x), .o_cur_y(o_cur_y),
        .o_next_x(o_next_x), .o_next_y(o_next_y),
        .o_new_cur_cell_states(o_new_cur_cell_states), .o_write_en(o_write_en),
        .o_cur_read_field(o_cur_read_field), .o_gen_done(o_gen_done),
        .o_gen_cnt(o_gen_cnt), .o_pop_cnt(o_pop_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int exp_field = 0;
    int exp_gen   = 0;
    int exp_pop   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic life(input logic c, input logic [7:0] n);
        int k;
        k = $countones(n);
        return (k == 3) || (c && (k == 2));
    endfunction

    // mode 0: random data; mode 1: every cell alive with exactly 3 live neighbours
    task automatic set_inputs(input int mode);
        for (int l = 0; l < L; l++) begin
            if (mode == 0) begin
                i_next_cell_states[l]  = 1'($urandom);
                i_next_nbrs[l*8 +: 8]  = 8'($urandom);
            end else begin
                i_next_cell_states[l]  = 1'b1;
                i_next_nbrs[l*8 +: 8]  = 8'h07;
            end
        end
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_sim"},   64'(o_is_simulating), 64'd0);
        chk({tag, "_done"},  64'(o_gen_done), 64'd0);
        chk({tag, "_nx"},    64'(o_next_x), 64'd0);
        chk({tag, "_ny"},    64'(o_next_y), 64'd0);
        chk({tag, "_field"}, 64'(o_cur_read_field), 64'(exp_field));
        chk({tag, "_gen"},   64'(o_gen_cnt), 64'(exp_gen));
        chk({tag, "_pop"},   64'(o_pop_cnt), 64'(exp_pop));
    endtask

    // Runs one full generation starting from IDLE or DONE and ends in the DONE cycle.
    task automatic do_sweep(input int mode, input bit use_run);
        logic [L-1:0]   pcs;
        logic [L*8-1:0] pnb;
        logic [L-1:0]   e;
        int             pop;
        int             g2;
        pop = 0;
        chk("start_nx", 64'(o_next_x), 64'd0);
        chk("start_ny", 64'(o_next_y), 64'd0);
        if (use_run) i_run = 1'b1; else i_go = 1'b1;
        set_inputs(mode);
        pcs = i_next_cell_states;
        pnb = i_next_nbrs;
        for (int g = 0; g < N; g++) begin
            step();
            i_go = 1'b0;
            g2 = (g + 1) % N;
            chk("sim",   64'(o_is_simulating), 64'd1);
            chk("wen",   64'(o_write_en), 64'd1);
            chk("gdone", 64'(o_gen_done), 64'd0);
            chk("cur_x", 64'(o_cur_x), 64'((g * L) % W));
            chk("cur_y", 64'(o_cur_y), 64'((g * L) / W));
            chk("nxt_x", 64'(o_next_x), 64'((g2 * L) % W));
            chk("nxt_y", 64'(o_next_y), 64'((g2 * L) / W));
            for (int l = 0; l < L; l++) e[l] = life(pcs[l], pnb[l*8 +: 8]);
            chk("new", 64'(o_new_cur_cell_states), 64'(e));
            pop += $countones(e);
            set_inputs(mode);
            pcs = i_next_cell_states;
            pnb = i_next_nbrs;
        end
        step();
        exp_field ^= 1;
        exp_gen   = (exp_gen + 1) % (1 << GW);
`ifdef POP_CNT_EN
        exp_pop = pop;
`else
        exp_pop = 0;
`endif
        chk("done_pulse", 64'(o_gen_done), 64'd1);
        chk("done_sim",   64'(o_is_simulating), 64'd0);
        chk("done_wen",   64'(o_write_en), 64'd0);
        chk("done_field", 64'(o_cur_read_field), 64'(exp_field));
        chk("done_gen",   64'(o_gen_cnt), 64'(exp_gen));
        chk("done_pop",   64'(o_pop_cnt), 64'(exp_pop));
    endtask

    initial begin
        rst = 1'b1; i_go = 1'b0; i_run = 1'b0; i_abort = 1'b0;
        i_next_cell_states = '0; i_next_nbrs = '0;
        step();
        step();
        chk("rst_sim",   64'(o_is_simulating), 64'd0);
        chk("rst_wen",   64'(o_write_en), 64'd0);
        chk("rst_done",  64'(o_gen_done), 64'd0);
        chk("rst_cur",   64'({o_cur_x, o_cur_y}), 64'd0);
        chk("rst_next",  64'({o_next_x, o_next_y}), 64'd0);
        chk("rst_new",   64'(o_new_cur_cell_states), 64'd0);
        chk("rst_field", 64'(o_cur_read_field), 64'd0);
        chk("rst_gen",   64'(o_gen_cnt), 64'd0);
        chk("rst_pop",   64'(o_pop_cnt), 64'd0);
        rst = 1'b0;
        step();
        check_idle("idle0");

        // single generation with random data
        do_sweep(0, 1'b0);
        step();
        check_idle("idle1");

        // three single-shot generations separated by random gaps
        for (int r = 0; r < 3; r++) begin
            repeat ($urandom_range(0, 4)) step();
            do_sweep(0, 1'b0);
        end
        step();
        check_idle("idle3");

        // free-run: four generations back-to-back
        for (int r = 0; r < 4; r++) do_sweep(0, 1'b1);
        i_run = 1'b0;
        step();
        check_idle("idle_run");

        // abort during the fifth SIM cycle
        i_go = 1'b1;
        set_inputs(0);
        for (int c = 0; c < 5; c++) begin
            step();
            i_go = 1'b0;
            set_inputs(0);
        end
        chk("abort_in_sim", 64'(o_is_simulating), 64'd1);
        i_abort = 1'b1;
        step();
        i_abort = 1'b0;
        check_idle("abort");
        step();
        chk("abort_no_done", 64'(o_gen_done), 64'd0);
        do_sweep(0, 1'b0);
        step();

        // reset in the middle of a sweep; the field is FIELD_B at this point
        chk("pre_rst_field", 64'(o_cur_read_field), 64'd1);
        i_go = 1'b1;
        set_inputs(0);
        for (int c = 0; c < 3; c++) begin
            step();
            i_go = 1'b0;
        end
        rst = 1'b1;
        step();
        exp_field = 0; exp_gen = 0; exp_pop = 0;
        chk("mrst_new", 64'(o_new_cur_cell_states), 64'd0);
        chk("mrst_cur", 64'({o_cur_x, o_cur_y}), 64'd0);
        chk("mrst_wen", 64'(o_write_en), 64'd0);
        check_idle("mrst");
        rst = 1'b0;
        step();

        // population: all cells alive with three live neighbours
        do_sweep(1, 1'b0);
`ifdef POP_CNT_EN
        chk("pop_full", 64'(o_pop_cnt), 64'd32);
`else
        chk("pop_off", 64'(o_pop_cnt), 64'd0);
`endif
        step();
        check_idle("idle_end");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/multi_lane_field_iter.md
# multi_lane_field_iter

Parametrised successor of the single-cell field iterator: sweeps the Game of Life field in raster order, processing `LANES` horizontally adjacent cells per clock. It issues next-read addresses, applies the `next_cell_state` rule per lane and produces write data. It flips the double-buffer selector (`cur_field_t`, FIELD_A/FIELD_B) at the end of each generation. It adds free-run mode, abort, a generation counter and an optional live-population count. It sits between the field memories and the display/control FSM.

## Interface

Parameters:
- `FIELD_W`, 8: field width in cells; ≥2; must be a multiple of `LANES`.
- `FIELD_H`, 4: field height in cells; ≥2.
- `LANES`, 2: cells processed per clock; power of two, ≥1.
- `GEN_W`, 16: generation counter width.
- Derived: `X_ADR_SIZE=$clog2(FIELD_W)`, `Y_ADR_SIZE=$clog2(FIELD_H)`, `NEIGHBOURS_CNT=8`, `POP_W=$clog2(FIELD_W*FIELD_H+1)`.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  synchronous, active-high reset.
- `i_go`  in  1  start one generation (sampled in IDLE/DONE).
- `i_run`  in  1  level; while high, generations start back-to-back.
- `i_abort`  in  1  abandon the current sweep.
- `i_next_cell_states`  in  LANES  current states of the group at `o_next_x/o_next_y`; lane k = x+k.
- `i_next_nbrs`  in  LANES*8  neighbour vectors; lane k in bits [8k+7:8k].
- `o_is_simulating`  out  1  high while in SIM.
- `o_cur_x`  out  X_ADR_SIZE  x of lane 0 of the group being written.
- `o_cur_y`  out  Y_ADR_SIZE  row being written.
- `o_next_x`, `o_next_y`  out  X/Y_ADR_SIZE  read address of the next group.
- `o_new_cur_cell_states`  out  LANES  new states for the `o_cur` group.
- `o_write_en`  out  1  write strobe; equals `o_is_simulating`.
- `o_cur_read_field`  out  cur_field_t  field currently read from.
- `o_gen_done`  out  1  one-cycle pulse after a completed sweep.
- `o_gen_cnt`  out  GEN_W  completed generations; wraps.
- `o_pop_cnt`  out  POP_W  live cells written in the last completed generation (`POP_CNT_EN` only).

## Operation

- States: IDLE, SIM, DONE.
- IDLE: `o_next=(0,0)`. `i_go|i_run` → SIM.
- SIM: each clock, register `i_next_*` and advance `cur←next`. x steps by `LANES`. At `x=FIELD_W-LANES`, x wraps to 0 and y increments. After `(FIELD_W-1-(LANES-1), FIELD_H-1)`, `o_next` wraps to (0,0).
- Last group written → DONE:
  - toggle `o_cur_read_field`;
  - `o_gen_cnt++`;
  - latch population.
- DONE: `o_gen_done=1`. `i_go|i_run` → SIM, otherwise IDLE.
- `i_abort` in SIM → IDLE next clock:
  - no field toggle, no count, no `o_gen_done`;
  - `o_next` resets to (0,0).
- `i_abort` outside SIM: ignored. `i_abort` has priority over end-of-sweep.
- Rule per lane: Conway B3/S23 via `next_cell_state` instances, fed from the registered inputs.

## Timing

- Reset values:
  - `o_is_simulating=0`, `o_write_en=0`, `o_gen_done=0`;
  - `o_cur_x/y=0`, `o_next_x/y=0`;
  - `o_new_cur_cell_states=0`;
  - `o_cur_read_field=FIELD_A`;
  - `o_gen_cnt=0`, `o_pop_cnt=0`.
- Reset mid-SIM returns to IDLE with all reset values; the field selector is restored to FIELD_A.
- Read latency: inputs presented in the cycle where `o_next` = G become `o_new_cur_cell_states` in the following cycle, when `o_cur` = G.
- In the `i_go` cycle (IDLE), inputs correspond to (0,0). The first SIM cycle shows `o_cur=(0,0)`, `o_next=(LANES,0)`.
- SIM lasts exactly `FIELD_W*FIELD_H/LANES` cycles, followed by one DONE cycle.
- Back-to-back generation period is SIM length + 1.
- `o_next` coordinates wrap modulo field size; no out-of-range address is ever emitted.

## Configuration

- `POP_CNT_EN` defined:
  - an accumulator sums the `o_new_cur_cell_states` popcount over every SIM cycle;
  - it clears at SIM entry and is copied to `o_pop_cnt` on transition to DONE;
  - abort discards it.
- Undefined: no accumulator; `o_pop_cnt` is tied to 0.

## Test plan

- W=8, H=3, LANES=2, random inputs, `i_go` once:
  - cur/next coordinates follow raster order (0,0),(2,0)…(6,2);
  - `o_new` matches the reference rule on the previous-cycle inputs;
  - `o_is_simulating` is high for 12 cycles, then `o_gen_done` pulses and the field becomes FIELD_B.
- LANES=1, W=5, H=3, three `i_go` pulses separated by random idle gaps:
  - behaviour is identical to the single-cell iterator;
  - the field alternates B, A, B;
  - `o_gen_cnt=3`.
- `i_run` held high for 4 generations (W=8, H=4, LANES=4): DONE pulses every 9 cycles, `o_gen_cnt=4`, never IDLE in between.
- `i_abort` at cycle 5 of SIM: IDLE next cycle, field unchanged, `o_gen_cnt` unchanged, no `o_gen_done`; the next `i_go` starts at (0,0).
- `rst` asserted mid-SIM: all outputs take reset values next cycle, including FIELD_A.
- `POP_CNT_EN`, W=8, H=4, LANES=2, all-ones states with nbrs=3 live: `o_pop_cnt=32` at DONE. Without the macro, `o_pop_cnt=0`.
